// File: rtl/io_bridge.sv
// Memory-mapped bridge between the CPU data bus, data RAM and the board I/O window.
// Optional per-button debounce is enabled by defining BTN_DEBOUNCE_EN.
module io_bridge #(
   parameter int unsigned DRAM_AW         = 14,
   parameter int unsigned SCAN_DIV        = 20000,
   parameter logic [31:0] TIMER_DIV_RST   = '0,
   parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
   input  logic               cpu_clk,
   input  logic               cpu_rst,
   input  logic [31:0]        Bus_addr,
   input  logic               Bus_wen,
   input  logic [31:0]        Bus_wdata,
   output logic [31:0]        Bus_rdata,
   output logic [DRAM_AW-1:0] dram_addr,
   output logic               dram_wen,
   output logic [31:0]        dram_wdata,
   input  logic [31:0]        dram_rdata,
   input  logic [23:0]        sw,
   input  logic [4:0]         button,
   output logic [23:0]        led,
   output logic [7:0]         dig_en,
   output logic [7:0]         dig_seg
);

   localparam logic [11:0] ADDR_DIG   = 12'h000;
   localparam logic [11:0] ADDR_TCNT  = 12'h020;
   localparam logic [11:0] ADDR_TDIV  = 12'h024;
   localparam logic [11:0] ADDR_LED   = 12'h060;
   localparam logic [11:0] ADDR_SW    = 12'h070;
   localparam logic [11:0] ADDR_BTN   = 12'h078;

   localparam int unsigned       SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   if (SCAN_DIV < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
      $error("io_bridge: SCAN_DIV and DEBOUNCE_CYCLES must be at least 1");
   end

   logic              io_sel;
   logic              wr_dig, wr_tcnt, wr_tdiv, wr_led;
   logic [31:0]       dig_reg;
   logic [23:0]       led_reg;
   logic [31:0]       tim_count, tim_div, tim_pre;
   logic              tim_tick;
   logic [SCAN_W-1:0] scan_cnt;
   logic [2:0]        scan_idx;
   logic [23:0]       sw_meta, sw_sync;
   logic [4:0]        btn_meta, btn_sync, btn_val;
   logic [3:0]        scan_nib;

   function automatic logic [7:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 8'hC0;
         4'h1: hex7 = 8'hF9;
         4'h2: hex7 = 8'hA4;
         4'h3: hex7 = 8'hB0;
         4'h4: hex7 = 8'h99;
         4'h5: hex7 = 8'h92;
         4'h6: hex7 = 8'h82;
         4'h7: hex7 = 8'hF8;
         4'h8: hex7 = 8'h80;
         4'h9: hex7 = 8'h90;
         4'hA: hex7 = 8'h88;
         4'hB: hex7 = 8'h83;
         4'hC: hex7 = 8'hC6;
         4'hD: hex7 = 8'hA1;
         4'hE: hex7 = 8'h86;
         default: hex7 = 8'h8E;
      endcase
   endfunction

   assign io_sel     = (Bus_addr[31:12] == 20'hFFFFF);
   assign dram_addr  = Bus_addr[DRAM_AW+1:2];
   assign dram_wen   = Bus_wen & ~io_sel;
   assign dram_wdata = Bus_wdata;

   assign wr_dig  = Bus_wen && io_sel && (Bus_addr[11:0] == ADDR_DIG);
   assign wr_tcnt = Bus_wen && io_sel && (Bus_addr[11:0] == ADDR_TCNT);
   assign wr_tdiv = Bus_wen && io_sel && (Bus_addr[11:0] == ADDR_TDIV);
   assign wr_led  = Bus_wen && io_sel && (Bus_addr[11:0] == ADDR_LED);

   always_comb begin
      Bus_rdata = '0;
      if (!io_sel) begin
         Bus_rdata = dram_rdata;
      end else begin
         case (Bus_addr[11:0])
            ADDR_DIG:  Bus_rdata = dig_reg;
            ADDR_TCNT: Bus_rdata = tim_count;
            ADDR_TDIV: Bus_rdata = tim_div;
            ADDR_LED:  Bus_rdata = {8'h00, led_reg};
            ADDR_SW:   Bus_rdata = {8'h00, sw_sync};
            ADDR_BTN:  Bus_rdata = {27'h0, btn_val};
            default:   Bus_rdata = '0;
         endcase
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         dig_reg <= '0;
         led_reg <= '0;
      end else begin
         if (wr_dig) dig_reg <= Bus_wdata;
         if (wr_led) led_reg <= Bus_wdata[23:0];
      end
   end

   assign led = led_reg;

   // A count write wins over a due increment; any timer write restarts the prescaler.
   assign tim_tick = (tim_pre == tim_div);

   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         tim_count <= '0;
         tim_div   <= TIMER_DIV_RST;
         tim_pre   <= '0;
      end else begin
         if (wr_tcnt)       tim_count <= Bus_wdata;
         else if (tim_tick) tim_count <= tim_count + 32'd1;
         if (wr_tdiv) tim_div <= Bus_wdata;
         if (wr_tcnt || wr_tdiv || tim_tick) tim_pre <= '0;
         else                                tim_pre <= tim_pre + 32'd1;
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         scan_cnt <= '0;
         scan_idx <= '0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         scan_idx <= scan_idx + 3'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   assign scan_nib = dig_reg[{scan_idx, 2'b00} +: 4];
   assign dig_en   = ~(8'b1 << scan_idx);
   assign dig_seg  = hex7(scan_nib);

   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         sw_meta  <= '0;
         sw_sync  <= '0;
         btn_meta <= '0;
         btn_sync <= '0;
      end else begin
         sw_meta  <= sw;
         sw_sync  <= sw_meta;
         btn_meta <= button;
         btn_sync <= btn_meta;
      end
   end

`ifdef BTN_DEBOUNCE_EN
   localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [4:0][DB_W-1:0] db_cnt;

   // Each counter tracks how long its synchronised button has disagreed with btn_val.
   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         btn_val <= '0;
         db_cnt  <= '0;
      end else begin
         for (int unsigned i = 0; i < 5; i++) begin
            if (btn_sync[i] != btn_val[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  btn_val[i] <= btn_sync[i];
                  db_cnt[i]  <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end
`else
   assign btn_val = btn_sync;
`endif

endmodule
